// File: rtl/lemming_arena.sv
// Environment partner for a lemming walker FSM: tracks the lemming's cell in a
// 1-D arena, pulses bump_left/bump_right at the walls and flags illegal directions.
module lemming_arena #(
    parameter int ARENA_W  = 16,
    parameter int STEP_DIV = 4,
    parameter int CNT_W    = 8
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic                       start,
    input  logic                       walk_left,
    input  logic                       walk_right,
    output logic                       bump_left,
    output logic                       bump_right,
    output logic [$clog2(ARENA_W)-1:0] pos,
    output logic [CNT_W-1:0]           bump_cnt,
    output logic                       err_dir
);

    localparam int POS_W  = $clog2(ARENA_W);
    localparam int TICK_W = $clog2(STEP_DIV);

    localparam logic [POS_W-1:0]  POS_RST   = POS_W'(ARENA_W / 2);
    localparam logic [POS_W-1:0]  POS_MAX   = POS_W'(ARENA_W - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [TICK_W-1:0]   r_tick;
    logic [TICK_W-1:0]   w_tick_nx;
    logic [POS_W-1:0]    r_pos;
    logic [POS_W-1:0]    w_pos_nx;
    logic                r_bump_l;
    logic                w_bump_l_nx;
    logic                r_bump_r;
    logic                w_bump_r_nx;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nx;
    logic                r_err;
    logic                w_err_nx;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state  <= IDLE;
            r_tick   <= '0;
            r_pos    <= POS_RST;
            r_bump_l <= 1'b0;
            r_bump_r <= 1'b0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_tick   <= w_tick_nx;
            r_pos    <= w_pos_nx;
            r_bump_l <= w_bump_l_nx;
            r_bump_r <= w_bump_r_nx;
            r_cnt    <= w_cnt_nx;
            r_err    <= w_err_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_tick_nx   = r_tick;
        w_pos_nx    = r_pos;
        w_bump_l_nx = 1'b0;
        w_bump_r_nx = 1'b0;
        w_cnt_nx    = r_cnt;
        w_err_nx    = r_err;

        case (r_state)
            IDLE: begin
                w_tick_nx = '0;
                if (start) begin
                    w_state_nx = RUN;
                end
            end
            RUN: begin
                if (r_tick == TICK_LAST) begin
                    w_tick_nx = '0;
                    // At a wall the step is refused and turned into a bump pulse.
                    case ({walk_left, walk_right})
                        2'b10: begin
                            if (r_pos == '0) begin
                                w_bump_l_nx = 1'b1;
                            end else begin
                                w_pos_nx = r_pos - POS_W'(1);
                            end
                        end
                        2'b01: begin
                            if (r_pos == POS_MAX) begin
                                w_bump_r_nx = 1'b1;
                            end else begin
                                w_pos_nx = r_pos + POS_W'(1);
                            end
                        end
                        default: begin
                            w_err_nx   = 1'b1;
                            w_state_nx = HALT;
                        end
                    endcase
                end else begin
                    w_tick_nx = r_tick + TICK_W'(1);
                end
            end
            HALT: begin
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase

        if ((w_bump_l_nx || w_bump_r_nx) && (r_cnt != '1)) begin
            w_cnt_nx = r_cnt + CNT_W'(1);
        end
    end

    assign bump_left  = r_bump_l;
    assign bump_right = r_bump_r;
    assign pos        = r_pos;
    assign bump_cnt   = r_cnt;
    assign err_dir    = r_err;

endmodule

// File: tb/tb_lemming_arena.sv
// Scoreboard bench for lemming_arena: a per-cycle behavioural arena model feeds
// expected-output queues that a separate monitor drains and compares.
module tb_lemming_arena;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start1 = 1'b0, wl1 = 1'b0, wr1 = 1'b0;
    logic       start2 = 1'b0, wl2 = 1'b0, wr2 = 1'b0;
    logic       bl1, br1, err1, bl2, br2, err2;
    logic [3:0] pos1;
    logic [7:0] cnt1;
    logic [0:0] pos2;
    logic [1:0] cnt2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lemming_arena #(.ARENA_W(16), .STEP_DIV(4), .CNT_W(8)) dut1 (
        .sys_clk(clk), .sys_rst(rst), .start(start1),
        .walk_left(wl1), .walk_right(wr1),
        .bump_left(bl1), .bump_right(br1), .pos(pos1),
        .bump_cnt(cnt1), .err_dir(err1)
    );

    lemming_arena #(.ARENA_W(2), .STEP_DIV(2), .CNT_W(2)) dut2 (
        .sys_clk(clk), .sys_rst(rst), .start(start2),
        .walk_left(wl2), .walk_right(wr2),
        .bump_left(bl2), .bump_right(br2), .pos(pos2),
        .bump_cnt(cnt2), .err_dir(err2)
    );

    // st: 0 idle, 1 running, 2 halted; cyc counts cycles spent running.
    typedef struct {
        int st;
        int cyc;
        int pos;
        int bl;
        int br;
        int cnt;
        int err;
    } mdl_t;

    mdl_t m1, m2;
    mdl_t q1[$];
    mdl_t q2[$];

    function automatic mdl_t mreset(int aw);
        mdl_t r;
        r.st = 0; r.cyc = 0; r.pos = aw / 2;
        r.bl = 0; r.br = 0; r.cnt = 0; r.err = 0;
        return r;
    endfunction

    function automatic mdl_t mstep(mdl_t m, bit r, bit s, bit l, bit rt,
                                   int aw, int sd, int cmax);
        mdl_t n;
        if (r) return mreset(aw);
        n = m;
        n.bl = 0;
        n.br = 0;
        if (m.st == 0) begin
            if (s) begin
                n.st = 1;
                n.cyc = 0;
            end
        end else if (m.st == 1) begin
            if (m.cyc % sd == sd - 1) begin
                if (l && !rt) begin
                    if (m.pos == 0) n.bl = 1;
                    else n.pos = m.pos - 1;
                end else if (!l && rt) begin
                    if (m.pos == aw - 1) n.br = 1;
                    else n.pos = m.pos + 1;
                end else begin
                    n.err = 1;
                    n.st = 2;
                end
                if ((n.bl + n.br) > 0 && m.cnt < cmax) n.cnt = m.cnt + 1;
            end
            n.cyc = m.cyc + 1;
        end
        return n;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", nm, $time, act, exp);
        end
    endtask

    // One clock of stimulus: inputs change on the falling edge, the model
    // advances to the state after the next rising edge and is queued.
    task automatic cyc(input bit r, input bit s, input bit l, input bit rt);
        bit d;
        @(negedge clk);
        d = 1'($urandom_range(0, 1));
        rst = r; start1 = s; wl1 = l; wr1 = rt;
        start2 = 1'b1; wl2 = d; wr2 = !d;
        m1 = mstep(m1, r, s, l, rt, 16, 4, 255);
        m2 = mstep(m2, r, 1'b1, d, !d, 2, 2, 3);
        q1.push_back(m1);
        q2.push_back(m2);
    endtask

    // Asynchronous reset in the middle of a cycle, checked before any edge.
    task automatic rst_now();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_pos", int'(pos1), 8);
        chk("rst_bl", int'(bl1), 0);
        chk("rst_br", int'(br1), 0);
        chk("rst_cnt", int'(cnt1), 0);
        chk("rst_err", int'(err1), 0);
        chk("rst_pos2", int'(pos2), 1);
        chk("rst_cnt2", int'(cnt2), 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        mdl_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("pos", int'(pos1), e.pos);
                chk("bump_left", int'(bl1), e.bl);
                chk("bump_right", int'(br1), e.br);
                chk("bump_cnt", int'(cnt1), e.cnt);
                chk("err_dir", int'(err1), e.err);
            end
            if (q2.size() > 0) begin
                e = q2.pop_front();
                chk("sat_pos", int'(pos2), e.pos);
                chk("sat_bump_left", int'(bl2), e.bl);
                chk("sat_bump_right", int'(br2), e.br);
                chk("sat_bump_cnt", int'(cnt2), e.cnt);
                chk("sat_err_dir", int'(err2), e.err);
            end
        end
    end

    initial begin : driver
        bit dir_l;
        bit l, rt, s;
        int len, r;
        m1 = mreset(16);
        m2 = mreset(2);

        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        rst_now();
        cyc(1'b0, 1'b0, 1'b1, 1'b0);

        // IDLE hold: walk_left ignored while start is low.
        repeat (50) cyc(1'b0, 1'b0, 1'b1, 1'b0);

        // Left wall run: 8 steps down to 0, then repeated bumps.
        repeat (48) cyc(1'b0, 1'b1, 1'b1, 1'b0);

        // Reset in the middle of a run discards any pending bump.
        rst_now();
        cyc(1'b0, 1'b1, 1'b1, 1'b0);

        // Closed loop: a walker that turns on every bump pulse.
        dir_l = 1'b1;
        repeat (300) begin
            cyc(1'b0, 1'b1, dir_l, !dir_l);
            if (m1.bl != 0) dir_l = 1'b0;
            if (m1.br != 0) dir_l = 1'b1;
        end

        // Random episodes with occasional illegal directions and start toggling.
        repeat (8) begin
            rst_now();
            len = int'($urandom_range(40, 160));
            dir_l = 1'($urandom_range(0, 1));
            repeat (len) begin
                r = int'($urandom_range(0, 39));
                if (r < 5) dir_l = !dir_l;
                l = dir_l;
                rt = !dir_l;
                if (r == 39) begin l = 1'b1; rt = 1'b1; end
                if (r == 38) begin l = 1'b0; rt = 1'b0; end
                s = 1'($urandom_range(0, 1));
                cyc(1'b0, s, l, rt);
            end
        end

        // Forced illegal direction, then start toggling while halted.
        rst_now();
        repeat (10) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (8) cyc(1'b0, 1'b1, 1'b1, 1'b1);
        repeat (20) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", q1.size() + q2.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
